// File: rtl/axil_mem_master.sv
// Single-beat request port to AXI4-Lite master bridge.
// One transaction in flight; registered response channel.
module axil_mem_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LOW = ADDR_WIDTH'(STRB_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE, WR, WR_B, RD_AR, RD_R, RESP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic                  aw_hs;
    logic                  w_hs;

    assign aw_hs = m_axil_awvalid && m_axil_awready;
    assign w_hs  = m_axil_wvalid && m_axil_wready;

    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;
    assign m_axil_wdata  = wdata_q;
    assign m_axil_wstrb  = wstrb_q;
    assign resp_rdata    = rdata_q;
    assign resp_err      = err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (req_valid) state_d = req_we ? WR : RD_AR;
            WR:    if ((aw_done_q || aw_hs) && (w_done_q || w_hs))
                       state_d = WR_B;
            WR_B:  if (m_axil_bvalid) state_d = RESP;
            RD_AR: if (m_axil_arready) state_d = RD_R;
            RD_R:  if (m_axil_rvalid) state_d = RESP;
            RESP:  if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs derived from registered state and done flags
    always_comb begin
        req_ready      = 1'b0;
        m_axil_awvalid = 1'b0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        resp_valid     = 1'b0;
        unique case (state_q)
            IDLE:  req_ready = 1'b1;
            WR: begin
                m_axil_awvalid = !aw_done_q;
                m_axil_wvalid  = !w_done_q;
            end
            WR_B:  m_axil_bready  = 1'b1;
            RD_AR: m_axil_arvalid = 1'b1;
            RD_R:  m_axil_rready  = 1'b1;
            RESP:  resp_valid     = 1'b1;
            default: ;
        endcase
    end

    // Request capture, channel done flags and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && req_valid) begin
                addr_q    <= req_addr & ~ADDR_LOW;
                wdata_q   <= req_wdata;
                wstrb_q   <= req_wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (state_q == WR_B && m_axil_bvalid) begin
                rdata_q <= '0;
                err_q   <= |m_axil_bresp;
            end
            if (state_q == RD_R && m_axil_rvalid) begin
                rdata_q <= m_axil_rdata;
                err_q   <= |m_axil_rresp;
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_master.sv
// Directed bench for axil_mem_master with a small
// AXI-Lite RAM slave model and configurable stalls.
module tb_axil_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [15:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_chk = 0;
    int n_fail = 0;
    int aw_n = 0;
    int w_n = 0;
    int b_n = 0;
    int aw_dly = 0;
    int w_dly = 0;
    logic [1:0] bresp_cfg = 2'b00;

    axil_mem_master dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    // Slave model state
    logic [31:0] mem [0:255];
    logic        aw_got, w_got;
    int          aw_cnt, w_cnt;
    logic [15:0] aw_q;
    logic [31:0] wd_q;
    logic [3:0]  ws_q;
    logic        aw_hs, w_hs;
    logic [15:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;
    assign wa = aw_hs ? awaddr : aw_q;
    assign wd = w_hs ? wdata : wd_q;
    assign ws = w_hs ? wstrb : ws_q;

    // Handshake monitors
    always @(posedge clk) begin
        if (aw_hs) aw_n <= aw_n + 1;
        if (w_hs) w_n <= w_n + 1;
        if (bvalid && bready) b_n <= b_n + 1;
    end

    // AXI-Lite RAM slave with per-channel ready delays
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awready <= 0; wready <= 0; arready <= 0;
            bvalid <= 0; rvalid <= 0; bresp <= 0;
            rresp <= 0; rdata <= 0;
            aw_got <= 0; w_got <= 0; aw_cnt <= 0; w_cnt <= 0;
            aw_q <= 0; wd_q <= 0; ws_q <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= '0;
            mem[8] <= 32'hAAAAAAAA;
        end else begin
            awready <= 0; wready <= 0; arready <= 0;
            if (awvalid && !awready && !aw_got) begin
                if (aw_cnt >= aw_dly) begin
                    awready <= 1; aw_cnt <= 0;
                end else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && !wready && !w_got) begin
                if (w_cnt >= w_dly) begin
                    wready <= 1; w_cnt <= 0;
                end else w_cnt <= w_cnt + 1;
            end
            if (aw_hs) begin aw_got <= 1; aw_q <= awaddr; end
            if (w_hs) begin w_got <= 1; wd_q <= wdata; ws_q <= wstrb; end
            if (bvalid && bready) bvalid <= 0;
            if (!bvalid && (aw_got || aw_hs) && (w_got || w_hs)) begin
                for (int i = 0; i < 4; i++)
                    if (ws[i]) mem[wa[9:2]][8*i +: 8] <= wd[8*i +: 8];
                bvalid <= 1; bresp <= bresp_cfg;
                aw_got <= 0; w_got <= 0;
            end
            if (arvalid && !arready && !rvalid) arready <= 1;
            if (arvalid && arready) begin
                rvalid <= 1; rdata <= mem[araddr[9:2]]; rresp <= 0;
            end
            if (rvalid && rready) rvalid <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request and return #1 after the accepting edge
    task automatic send(input logic we, input logic [15:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a;
        req_wdata = d; req_wstrb = s;
        while (!req_ready && n < 50) begin
            @(negedge clk); n++;
        end
        check("accept", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1 req_valid = 0;
    endtask

    // Edges from the accepting edge until resp_valid is seen
    task automatic wait_resp(output int lat);
        lat = 1;
        while (lat < 60) begin
            @(negedge clk);
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
        check("resp_timeout", 32'(lat < 60), 32'd1);
    endtask

    task automatic consume;
        @(posedge clk);
        @(negedge clk);
        check("resp_drop", 32'(resp_valid), 32'd0);
    endtask

    int lat, a0, w0, b0, n;
    logic [31:0] held;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", 32'(awvalid), 0);
        check("rst_wvalid", 32'(wvalid), 0);
        check("rst_arvalid", 32'(arvalid), 0);
        check("rst_bready", 32'(bready), 0);
        check("rst_rready", 32'(rready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_addr", 32'(awaddr), 0);
        rst_n = 1;

        // 1: full-strobe write
        a0 = aw_n; w0 = w_n; b0 = b_n;
        send(1, 16'h0010, 32'hDEADBEEF, 4'hF);
        check("t1_awvalid", 32'(awvalid), 1);
        check("t1_wvalid", 32'(wvalid), 1);
        check("t1_awaddr", 32'(awaddr), 32'h10);
        check("t1_awprot", 32'(awprot), 0);
        wait_resp(lat);
        check("t1_lat", lat, 4);
        check("t1_err", 32'(resp_err), 0);
        check("t1_rdata", resp_rdata, 0);
        consume();
        check("t1_mem4", mem[4], 32'hDEADBEEF);
        check("t1_aw_n", aw_n - a0, 1);
        check("t1_w_n", w_n - w0, 1);
        check("t1_b_n", b_n - b0, 1);

        // 2: read back, unaligned address is word-aligned
        send(0, 16'h0012, 32'h0, 4'h0);
        check("t2_arvalid", 32'(arvalid), 1);
        check("t2_araddr", 32'(araddr), 32'h10);
        check("t2_arprot", 32'(arprot), 0);
        wait_resp(lat);
        check("t2_lat", lat, 4);
        check("t2_rdata", resp_rdata, 32'hDEADBEEF);
        check("t2_err", 32'(resp_err), 0);
        consume();

        // 3: partial-strobe write over 0xAAAAAAAA
        send(1, 16'h0020, 32'h11223344, 4'b0101);
        wait_resp(lat);
        consume();
        send(0, 16'h0020, 32'h0, 4'h0);
        wait_resp(lat);
        check("t3_rdata", resp_rdata, 32'hAA22AA44);
        consume();

        // 4: W channel stalled two cycles beyond AW
        w_dly = 2;
        a0 = aw_n; w0 = w_n; b0 = b_n;
        send(1, 16'h0030, 32'h55667788, 4'hF);
        @(negedge clk);
        check("t4_c1_awvalid", 32'(awvalid), 1);
        check("t4_c1_wvalid", 32'(wvalid), 1);
        @(negedge clk);
        @(negedge clk);
        check("t4_c3_awvalid", 32'(awvalid), 0);
        check("t4_c3_wvalid", 32'(wvalid), 1);
        wait_resp(lat);
        check("t4_err", 32'(resp_err), 0);
        consume();
        check("t4_aw_n", aw_n - a0, 1);
        check("t4_w_n", w_n - w0, 1);
        check("t4_b_n", b_n - b0, 1);
        w_dly = 0;

        // 5: response back-pressure blocks new requests
        resp_ready = 0;
        send(0, 16'h0030, 32'h0, 4'h0);
        wait_resp(lat);
        held = resp_rdata;
        check("t5_rdata", held, 32'h55667788);
        req_valid = 1; req_we = 1; req_addr = 16'h0030;
        req_wdata = 32'hFFFFFFFF; req_wstrb = 4'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_req_ready", 32'(req_ready), 0);
            check("t5_hold", resp_rdata, held);
        end
        resp_ready = 1;
        @(negedge clk);
        check("t5_release_ready", 32'(req_ready), 1);
        check("t5_release_valid", 32'(resp_valid), 0);
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        check("t5_next_awvalid", 32'(awvalid), 1);
        wait_resp(lat);
        check("t5_strb0_err", 32'(resp_err), 0);
        consume();
        send(0, 16'h0030, 32'h0, 4'h0);
        wait_resp(lat);
        check("t5_strb0_keep", resp_rdata, 32'h55667788);
        consume();

        // 6: reset in RD_R, then error response on write
        send(0, 16'h0010, 32'h0, 4'h0);
        n = 0;
        while (!rready && n < 20) begin
            @(negedge clk); n++;
        end
        check("t6_reach_rd_r", 32'(rready), 1);
        rst_n = 0;
        #1;
        check("t6_rst_rready", 32'(rready), 0);
        check("t6_rst_arvalid", 32'(arvalid), 0);
        check("t6_rst_resp_valid", 32'(resp_valid), 0);
        check("t6_rst_rdata", resp_rdata, 0);
        check("t6_rst_araddr", 32'(araddr), 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("t6_no_resp", 32'(resp_valid), 0);
        bresp_cfg = 2'b10;
        send(1, 16'h0040, 32'h01020304, 4'hF);
        wait_resp(lat);
        check("t6_err", 32'(resp_err), 1);
        check("t6_rdata", resp_rdata, 0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
